// File: rtl/modality_fusion_ngram_pkg.sv
// Shared definitions for the modality fusion / temporal N-gram block.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
// Contents: default hypervector width, default window length, FSM state encoding,
//           ceil_log2 for sizing the window fill counter (ceil_log2(N+1)).
package modality_fusion_ngram_pkg;

  localparam int HV_DIMENSION       = 2000;
  localparam int NGRAM_SIZE_DEFAULT = 3;

  // FILL: window not yet full; OUT: result pending downstream; WAIT: window full, idle.
  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_OUT  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  function automatic int ceil_log2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/modality_fusion_ngram_hv_majority3.sv
// Bitwise 3-input majority across three DIM-wide hypervectors.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of the inputs).
// Ports: a, b, c - input hypervectors [0:DIM-1]; y - per-bit majority [0:DIM-1].
module hv_majority3
  import modality_fusion_ngram_pkg::*;
#(
  parameter int DIM = HV_DIMENSION
) (
  input  logic [0:DIM-1] a,
  input  logic [0:DIM-1] b,
  input  logic [0:DIM-1] c,
  output logic [0:DIM-1] y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/modality_fusion_ngram.sv
// Fuses three modality hypervectors by majority and builds a rotate-and-XOR temporal N-gram.
// Latency: accept at edge t -> ValidOut_SO/HypervectorOut_DO valid right after edge t.
// Backpressure: result held in OUT until ReadyIn_SI; ReadyOut_SO low meanwhile, nothing dropped.
// Ports: Clk_CI clock, Reset_RBI sync active-low reset, ValidIn_SI/ReadyOut_SO input handshake,
//        HypervectorIn_mod{1,2,3}_DI modality vectors, FlushIn_SI new-sequence request,
//        ValidOut_SO/ReadyIn_SI output handshake, HypervectorOut_DO registered result.
// Build option: define TEMPORAL_NGRAM_EN for the N-gram window; without it the fused vector is
//        registered directly on every accept and FlushIn_SI has no effect.
module modality_fusion_ngram
  import modality_fusion_ngram_pkg::*;
#(
  parameter int DIM        = HV_DIMENSION,
  parameter int NGRAM_SIZE = NGRAM_SIZE_DEFAULT
) (
  input  logic           Clk_CI,
  input  logic           Reset_RBI,
  input  logic           ValidIn_SI,
  output logic           ReadyOut_SO,
  input  logic [0:DIM-1] HypervectorIn_mod1_DI,
  input  logic [0:DIM-1] HypervectorIn_mod2_DI,
  input  logic [0:DIM-1] HypervectorIn_mod3_DI,
  input  logic           FlushIn_SI,
  output logic           ValidOut_SO,
  input  logic           ReadyIn_SI,
  output logic [0:DIM-1] HypervectorOut_DO
);

  state_t         state;
  logic           ready_q;
  logic           valid_q;
  logic [0:DIM-1] out_q;
  logic [0:DIM-1] fused;
  logic           accept;
  logic           xfer;

  hv_majority3 #(
    .DIM(DIM)
  ) u_majority (
    .a(HypervectorIn_mod1_DI),
    .b(HypervectorIn_mod2_DI),
    .c(HypervectorIn_mod3_DI),
    .y(fused)
  );

  assign accept = ValidIn_SI && ready_q;
  assign xfer   = valid_q && ReadyIn_SI;

  assign ReadyOut_SO       = ready_q;
  assign ValidOut_SO       = valid_q;
  assign HypervectorOut_DO = out_q;

`ifdef TEMPORAL_NGRAM_EN

  localparam int                CNT_W    = ceil_log2(NGRAM_SIZE + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NGRAM_SIZE);

  logic [CNT_W-1:0]                  fill_cntr;
  logic [CNT_W-1:0]                  cnt_base;
  logic [CNT_W-1:0]                  cnt_next;
  logic                              flush_pend;
  logic [NGRAM_SIZE-1:0][0:DIM-1]    hist_q;
  logic [NGRAM_SIZE-1:0][0:DIM-1]    hist_d;
  logic [NGRAM_SIZE-1:0][0:DIM-1]    xor_acc;
  logic [0:DIM-1]                    unused_hist_tail;

  // The oldest entry only ever feeds the output through hist_d of the same accept;
  // after that it is shifted out without being read.
  assign unused_hist_tail = hist_q[NGRAM_SIZE-1];

  // Next history and running XOR are formed from the incoming vector, so the result of an
  // accept can be registered at that same edge.
  genvar k;
  generate
    for (k = 0; k < NGRAM_SIZE; k++) begin : g_win
      if (k == 0) begin : g_head
        assign hist_d[0]  = fused;
        assign xor_acc[0] = fused;
      end else begin : g_tail
        assign hist_d[k]  = {hist_q[k-1][DIM-1], hist_q[k-1][0:DIM-2]};
        assign xor_acc[k] = xor_acc[k-1] ^ hist_d[k];
      end
    end
  endgenerate

  // A flush coinciding with an accept restarts the count first, so the new vector counts as 1.
  always_comb begin
    cnt_base = FlushIn_SI ? '0 : fill_cntr;
    cnt_next = (cnt_base == CNT_FULL) ? CNT_FULL : cnt_base + CNT_W'(1);
  end

  always_ff @(posedge Clk_CI) begin
    if (!Reset_RBI) begin
      state      <= ST_FILL;
      fill_cntr  <= '0;
      flush_pend <= 1'b0;
      hist_q     <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      case (state)
        ST_FILL, ST_WAIT: begin
          if (accept) begin
            hist_q    <= hist_d;
            fill_cntr <= cnt_next;
            if (cnt_next == CNT_FULL) begin
              out_q   <= xor_acc[NGRAM_SIZE-1];
              valid_q <= 1'b1;
              ready_q <= 1'b0;
              state   <= ST_OUT;
            end else begin
              state   <= ST_FILL;
            end
          end else if (FlushIn_SI) begin
            fill_cntr <= '0;
            state     <= ST_FILL;
          end
        end
        ST_OUT: begin
          // A flush seen while the result is pending is remembered and applied after delivery.
          if (xfer) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            if (flush_pend || FlushIn_SI) begin
              flush_pend <= 1'b0;
              fill_cntr  <= '0;
              state      <= ST_FILL;
            end else begin
              state      <= ST_WAIT;
            end
          end else if (FlushIn_SI) begin
            flush_pend <= 1'b1;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state   <= ST_FILL;
        end
      endcase
    end
  end

`else

  logic unused_flush;
  assign unused_flush = FlushIn_SI;

  always_ff @(posedge Clk_CI) begin
    if (!Reset_RBI) begin
      state   <= ST_FILL;
      out_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        ST_FILL: begin
          if (accept) begin
            out_q   <= fused;
            valid_q <= 1'b1;
            ready_q <= 1'b0;
            state   <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (xfer) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= ST_FILL;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state   <= ST_FILL;
        end
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_modality_fusion_ngram.sv
// Self-checking bench for modality_fusion_ngram (DIM=8, NGRAM_SIZE=3).
// Reference model: per-bit vote count for fusion, a queue of recent fused vectors per window,
// N-gram = XOR of each queued vector rotated by its age. Follows the same build option as the RTL.
module tb_modality_fusion_ngram;

  localparam int DIM = 8;
  localparam int N   = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           vin;
  logic           rdy_out;
  logic           flush;
  logic           vout;
  logic           rdy_in;
  logic [0:DIM-1] m1;
  logic [0:DIM-1] m2;
  logic [0:DIM-1] m3;
  logic [0:DIM-1] hout;

  always #5 clk = ~clk;

  modality_fusion_ngram #(
    .DIM(DIM),
    .NGRAM_SIZE(N)
  ) dut (
    .Clk_CI(clk),
    .Reset_RBI(rst_n),
    .ValidIn_SI(vin),
    .ReadyOut_SO(rdy_out),
    .HypervectorIn_mod1_DI(m1),
    .HypervectorIn_mod2_DI(m2),
    .HypervectorIn_mod3_DI(m3),
    .FlushIn_SI(flush),
    .ValidOut_SO(vout),
    .ReadyIn_SI(rdy_in),
    .HypervectorOut_DO(hout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: vectors accepted since the last flush/reset (newest first), fill count, last output.
  logic [7:0] m_win[$];
  int         m_cnt;
  logic [7:0] m_last;

  function automatic logic [7:0] maj(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
    return r;
  endfunction

  // Rotation by k positions towards higher bit index (rightwards in MSB-first hex).
  function automatic logic [7:0] rotr(input logic [7:0] x, input int k);
    if (k == 0) return x;
    return (x >> k) | (x << (8 - k));
  endfunction

  task automatic model_reset();
    m_win.delete();
    m_cnt  = 0;
    m_last = '0;
  endtask

  task automatic model_flush();
`ifdef TEMPORAL_NGRAM_EN
    m_cnt = 0;
`endif
  endtask

  task automatic model_accept(input logic [7:0] f, input logic fl, output logic ev, output logic [7:0] ed);
`ifdef TEMPORAL_NGRAM_EN
    if (fl) m_cnt = 0;
    m_win.push_front(f);
    if (m_win.size() > N) void'(m_win.pop_back());
    if (m_cnt < N) m_cnt++;
    ev = (m_cnt == N);
    ed = m_last;
    if (ev) begin
      ed = '0;
      for (int k = 0; k < m_win.size(); k++) ed = ed ^ rotr(m_win[k], k);
    end
`else
    ev = 1'b1;
    ed = f;
`endif
    m_last = ed;
  endtask

  task automatic idle(input int n);
    vin   = 1'b0;
    flush = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one input, waits (bounded) for ReadyOut_SO, lets it be accepted, samples outputs #1 later.
  task automatic do_accept(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic fl,
                           output logic vld, output logic [7:0] dat, output logic timed_out);
    int t;
    t     = 0;
    vin   = 1'b1;
    m1    = a;
    m2    = b;
    m3    = c;
    flush = fl;
    while (rdy_out !== 1'b1 && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    timed_out = (t >= 20);
    @(posedge clk);
    #1;
    vin   = 1'b0;
    flush = 1'b0;
    vld   = vout;
    dat   = hout;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    vin    = 1'b1;
    flush  = 1'b0;
    rdy_in = 1'b1;
    m1 = 8'hFF; m2 = 8'hFF; m3 = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    vin   = 1'b0;
    model_reset();
    n_tests++; if (vout !== 1'b0) begin n_fail++; $display("FAIL reset_vld got=%b exp=0", vout); end
    n_tests++; if (hout !== 8'h00) begin n_fail++; $display("FAIL reset_out got=%h exp=00", hout); end
    n_tests++; if (rdy_out !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got=%b exp=1", rdy_out); end
  endtask

  task automatic test_majority();
    logic v, to, ev;
    logic [7:0] d, ed;
    int reps;
`ifdef TEMPORAL_NGRAM_EN
    reps = N;
`else
    reps = 1;
`endif
    for (int i = 0; i < reps; i++) begin
      do_accept(8'hF0, 8'hCC, 8'hAA, 1'b0, v, d, to);
      model_accept(maj(8'hF0, 8'hCC, 8'hAA), 1'b0, ev, ed);
      n_tests++; if (to) begin n_fail++; $display("FAIL maj_timeout got=1 exp=0"); end
      n_tests++; if (v !== ev) begin n_fail++; $display("FAIL maj_vld[%0d] got=%b exp=%b", i, v, ev); end
      n_tests++; if (d !== ed) begin n_fail++; $display("FAIL maj_out[%0d] got=%h exp=%h", i, d, ed); end
    end
`ifdef TEMPORAL_NGRAM_EN
    n_tests++; if (d !== 8'hA6) begin n_fail++; $display("FAIL maj_ngram_const got=%h exp=a6", d); end
`else
    n_tests++; if (d !== 8'hE8) begin n_fail++; $display("FAIL maj_const got=%h exp=e8", d); end
`endif
  endtask

  task automatic test_ngram_fill();
    logic [7:0] seq [4];
    logic v, to, ev;
    logic [7:0] d, ed;
    seq = '{8'h80, 8'h01, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      do_accept(seq[i], seq[i], seq[i], i == 0, v, d, to);
      model_accept(seq[i], i == 0, ev, ed);
      n_tests++; if (to) begin n_fail++; $display("FAIL fill_timeout[%0d] got=1 exp=0", i); end
      n_tests++; if (v !== ev) begin n_fail++; $display("FAIL fill_vld[%0d] got=%b exp=%b", i, v, ev); end
      n_tests++; if (d !== ed) begin n_fail++; $display("FAIL fill_out[%0d] got=%h exp=%h", i, d, ed); end
`ifdef TEMPORAL_NGRAM_EN
      if (i == 2) begin
        n_tests++; if (d !== 8'hA0) begin n_fail++; $display("FAIL fill_const got=%h exp=a0", d); end
      end
      if (i == 3) begin
        n_tests++; if (d !== 8'h40) begin n_fail++; $display("FAIL slide_const got=%h exp=40", d); end
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    logic v, to, ev;
    logic [7:0] d, ed, a;
    idle(1);
    rdy_in = 1'b0;
    a = 8'($urandom);
    do_accept(a, a, 8'($urandom), 1'b0, v, d, to);
    model_accept(a, 1'b0, ev, ed);
    n_tests++; if (v !== 1'b1 || d !== ed) begin n_fail++; $display("FAIL bp_first got=%b/%h exp=1/%h", v, d, ed); end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (vout !== 1'b1 || hout !== ed || rdy_out !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d] got vld=%b out=%h rdy=%b exp 1/%h/0", i, vout, hout, rdy_out, ed);
      end
      @(posedge clk);
      #1;
    end
    rdy_in = 1'b1;
    @(posedge clk);
    #1;
    n_tests++; if (vout !== 1'b0 || rdy_out !== 1'b1) begin n_fail++; $display("FAIL bp_release got vld=%b rdy=%b exp 0/1", vout, rdy_out); end
    a = 8'($urandom);
    do_accept(a, a, a, 1'b0, v, d, to);
    model_accept(a, 1'b0, ev, ed);
    n_tests++; if (v !== ev || d !== ed) begin n_fail++; $display("FAIL bp_after got=%b/%h exp=%b/%h", v, d, ev, ed); end
  endtask

  task automatic test_flush_wait();
    logic [7:0] seq [3];
    logic v, to, ev;
    logic [7:0] d, ed;
    seq = '{8'h80, 8'h01, 8'h00};
    idle(2);
    for (int i = 0; i < 3; i++) begin
      do_accept(seq[i], seq[i], seq[i], i == 0, v, d, to);
      model_accept(seq[i], i == 0, ev, ed);
      n_tests++; if (v !== ev || d !== ed) begin n_fail++; $display("FAIL flushw[%0d] got=%b/%h exp=%b/%h", i, v, d, ev, ed); end
`ifdef TEMPORAL_NGRAM_EN
      n_tests++; if (v !== (i == 2)) begin n_fail++; $display("FAIL flushw_vld_const[%0d] got=%b", i, v); end
`endif
    end
`ifdef TEMPORAL_NGRAM_EN
    n_tests++; if (d !== 8'hA0) begin n_fail++; $display("FAIL flushw_const got=%h exp=a0", d); end
`endif
  endtask

  task automatic test_flush_out();
    logic v, to, ev;
    logic [7:0] d, ed, a, held;
    int xfers;
    idle(1);
    rdy_in = 1'b0;
    a = 8'($urandom);
    do_accept(a, 8'($urandom), a, 1'b0, v, d, to);
    model_accept(a, 1'b0, ev, ed);
    held = ed;
    n_tests++; if (v !== ev || d !== ed) begin n_fail++; $display("FAIL flusho_first got=%b/%h exp=%b/%h", v, d, ev, ed); end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    model_flush();
    n_tests++; if (vout !== 1'b1 || hout !== held) begin n_fail++; $display("FAIL flusho_hold got=%b/%h exp=1/%h", vout, hout, held); end
    rdy_in = 1'b1;
    xfers = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      if (vout === 1'b1) xfers++;
      #1;
    end
    n_tests++; if (xfers !== 1) begin n_fail++; $display("FAIL flusho_xfers got=%0d exp=1", xfers); end
    for (int i = 0; i < 3; i++) begin
      a = 8'($urandom);
      do_accept(a, a, 8'($urandom), 1'b0, v, d, to);
      model_accept(a, 1'b0, ev, ed);
      n_tests++; if (v !== ev || d !== ed) begin n_fail++; $display("FAIL flusho[%0d] got=%b/%h exp=%b/%h", i, v, d, ev, ed); end
`ifdef TEMPORAL_NGRAM_EN
      n_tests++; if (v !== (i == 2)) begin n_fail++; $display("FAIL flusho_vld_const[%0d] got=%b", i, v); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    logic v, to, ev;
    logic [7:0] d, ed, a;
    for (int i = 0; i < 2; i++) begin
      a = 8'($urandom);
      do_accept(a, a, a, i == 0, v, d, to);
      model_accept(a, i == 0, ev, ed);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    n_tests++; if (vout !== 1'b0 || hout !== 8'h00) begin n_fail++; $display("FAIL rstmid got=%b/%h exp=0/00", vout, hout); end
    n_tests++; if (rdy_out !== 1'b1) begin n_fail++; $display("FAIL rstmid_rdy got=%b exp=1", rdy_out); end
    for (int i = 0; i < 3; i++) begin
      a = 8'($urandom);
      do_accept(a, 8'($urandom), a, 1'b0, v, d, to);
      model_accept(a, 1'b0, ev, ed);
      n_tests++; if (v !== ev || d !== ed) begin n_fail++; $display("FAIL rstmid[%0d] got=%b/%h exp=%b/%h", i, v, d, ev, ed); end
`ifdef TEMPORAL_NGRAM_EN
      n_tests++; if (v !== (i == 2)) begin n_fail++; $display("FAIL rstmid_vld_const[%0d] got=%b", i, v); end
`endif
    end
  endtask

  task automatic test_random();
    logic v, to, ev, fl;
    logic [7:0] d, ed, a, b, c;
    for (int i = 0; i < 60; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      c  = 8'($urandom);
      fl = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      do_accept(a, b, c, fl, v, d, to);
      model_accept(maj(a, b, c), fl, ev, ed);
      n_tests++; if (to) begin n_fail++; $display("FAIL rand_timeout[%0d] got=1 exp=0", i); end
      n_tests++; if (v !== ev || d !== ed) begin n_fail++; $display("FAIL rand[%0d] got=%b/%h exp=%b/%h", i, v, d, ev, ed); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_majority();
    test_ngram_fill();
    test_backpressure();
    test_flush_wait();
    test_flush_out();
    test_reset_mid();
    test_random();
    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
